// File: rtl/gerador_pulso.sv
// -----------------------------------------------------------------------------
// gerador_pulso
//
// Turns single-cycle strobes (for example rising-edge detections) back into
// clean level pulses of PULSE_LEN cycles. Each pulse is followed by a forced
// low gap of GAP_LEN cycles. Every channel is independent and has its own
// counter, its own busy flag and a sticky flag for strobes it had to drop.
//
// Per-channel states:
//   OCIOSO - idle, waiting for a strobe
//   ATIVO  - pulse output high, counting down PULSE_LEN cycles
//   PAUSA  - forced low gap, counting down GAP_LEN cycles
//
// Build option (macro RETRIGGER_EN):
//   defined   - a strobe in ATIVO reloads the pulse counter, which extends
//               the pulse. A strobe on the final ATIVO cycle also reloads, so
//               the output stays high with no low cycle. Strobes in PAUSA are
//               still dropped.
//   undefined - strobes in ATIVO are dropped and set perdido (default build).
// -----------------------------------------------------------------------------
module gerador_pulso #(
  parameter int CHANNELS  = 2,
  parameter int PULSE_LEN = 4,  // output high time in cycles, >= 1
  parameter int GAP_LEN   = 2   // forced low time after each pulse, >= 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] dispara,
  output logic [CHANNELS-1:0] pulso,
  output logic [CHANNELS-1:0] ocupado,
  output logic [CHANNELS-1:0] perdido
);

  // Counter must hold the larger of the two reload values.
  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD   =
    (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

`ifdef RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  typedef enum logic [1:0] {
    OCIOSO = 2'b00,
    ATIVO  = 2'b01,
    PAUSA  = 2'b10
  } estado_t;

  // Per-channel state and countdown
  estado_t          r_estado     [CHANNELS];
  logic [CNT_W-1:0] r_cnt        [CHANNELS];
  estado_t          w_estado_prox[CHANNELS];
  logic [CNT_W-1:0] w_cnt_prox   [CHANNELS];

  // Registered outputs and their next values
  logic [CHANNELS-1:0] r_pulso;
  logic [CHANNELS-1:0] r_ocupado;
  logic [CHANNELS-1:0] r_perdido;
  logic [CHANNELS-1:0] w_pulso_prox;
  logic [CHANNELS-1:0] w_ocupado_prox;
  logic [CHANNELS-1:0] w_perdido_prox;
  logic [CHANNELS-1:0] w_descarte;

  // Next-state, counter and output decode for every channel
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis would infer a latch to hold the value.
      w_estado_prox[i] = r_estado[i];
      w_cnt_prox[i]    = r_cnt[i];
      w_descarte[i]    = 1'b0;

      unique case (r_estado[i])
        OCIOSO: begin
          if (dispara[i]) begin
            w_estado_prox[i] = ATIVO;
            w_cnt_prox[i]    = PULSE_RELOAD;
          end
        end

        ATIVO: begin
          if (RETRIGGER && dispara[i]) begin
            // Reload keeps the output high, including on the final cycle.
            w_cnt_prox[i] = PULSE_RELOAD;
          end else if (r_cnt[i] == '0) begin
            if (GAP_LEN > 0) begin
              w_estado_prox[i] = PAUSA;
              w_cnt_prox[i]    = GAP_RELOAD;
            end else begin
              w_estado_prox[i] = OCIOSO;
            end
          end else begin
            w_cnt_prox[i] = r_cnt[i] - CNT_ONE;
          end
          // Without retrigger, a strobe during the pulse is lost.
          w_descarte[i] = dispara[i] && !RETRIGGER;
        end

        PAUSA: begin
          // Strobes are dropped for the whole gap, last cycle included.
          w_descarte[i] = dispara[i];
          if (r_cnt[i] == '0) begin
            w_estado_prox[i] = OCIOSO;
          end else begin
            w_cnt_prox[i] = r_cnt[i] - CNT_ONE;
          end
        end

        default: begin
          // Unused encoding: recover to idle.
          w_estado_prox[i] = OCIOSO;
          w_cnt_prox[i]    = '0;
        end
      endcase

      // Outputs are registered copies of the next state so they line up with it.
      w_pulso_prox[i]   = (w_estado_prox[i] == ATIVO);
      w_ocupado_prox[i] = (w_estado_prox[i] != OCIOSO);
      w_perdido_prox[i] = r_perdido[i] | w_descarte[i];
    end
  end

  // State, counter and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they
      // are reset together with the outputs to give a known idle start.
      for (int i = 0; i < CHANNELS; i++) begin
        r_estado[i] <= OCIOSO;
        r_cnt[i]    <= '0;
      end
      r_pulso   <= '0;
      r_ocupado <= '0;
      r_perdido <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      for (int i = 0; i < CHANNELS; i++) begin
        r_estado[i] <= w_estado_prox[i];
        r_cnt[i]    <= w_cnt_prox[i];
      end
      r_pulso   <= w_pulso_prox;
      r_ocupado <= w_ocupado_prox;
      r_perdido <= w_perdido_prox;
    end
  end

  assign pulso   = r_pulso;
  assign ocupado = r_ocupado;
  assign perdido = r_perdido;

endmodule

// File: tb/tb_gerador_pulso.sv
// -----------------------------------------------------------------------------
// tb_gerador_pulso
//
// Two instances: dut_a (2 channels, PULSE_LEN=4, GAP_LEN=2) and dut_b
// (1 channel, PULSE_LEN=3, GAP_LEN=0). Directed scenarios use hand-derived
// expectations. The random scenario uses a timestamp model: each channel
// remembers the edge at which its current pulse started, and every output is
// a window test on that edge number.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_gerador_pulso;

  localparam int PA = 4;
  localparam int GA = 2;
  localparam int PB = 3;
  localparam int GB = 0;

`ifdef RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dispara_a = '0;
  logic [1:0] pulso_a, ocupado_a, perdido_a;
  logic [0:0] dispara_b = '0;
  logic [0:0] pulso_b, ocupado_b, perdido_b;

  int total = 0;
  int bad   = 0;

  gerador_pulso #(.CHANNELS(2), .PULSE_LEN(PA), .GAP_LEN(GA)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .dispara (dispara_a),
    .pulso   (pulso_a),
    .ocupado (ocupado_a),
    .perdido (perdido_a)
  );

  gerador_pulso #(.CHANNELS(1), .PULSE_LEN(PB), .GAP_LEN(GB)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .dispara (dispara_b),
    .pulso   (pulso_b),
    .ocupado (ocupado_b),
    .perdido (perdido_b)
  );

  always #5 clk = ~clk;

  // Reference model step for one channel: s is the edge at which the current
  // pulse began, p the sticky drop flag, m the edge being processed.
  function automatic void model_step(input int m, input bit d, input int p_len,
                                     input int g_len, inout int s, inout bit p);
    if (d) begin
      if (m >= s + p_len + g_len + 1) s = m;        // idle: accept
      else if (RETRIG && m <= s + p_len) s = m;     // pulse running: reload
      else p = 1'b1;                                // dropped
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    dispara_a = '0;
    dispara_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    dispara_a = 2'b11;
    dispara_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({pulso_a, ocupado_a, perdido_a, pulso_b, ocupado_b, perdido_b} !== 9'b0) begin
        bad++;
        $display("FAIL reset cyc%0d: got a=%b%b%b b=%b%b%b expected all zero",
                 k, pulso_a, ocupado_a, perdido_a, pulso_b, ocupado_b, perdido_b);
      end
    end
    dispara_a = '0;
    dispara_b = '0;
    rst       = 1'b0;
  endtask

  task automatic test_single();
    logic [5:0] exp_v;
    do_reset();
    dispara_a = 2'b01;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      dispara_a = 2'b00;
      exp_v = {1'b0, 1'(k < 4), 1'b0, 1'(k < 6), 2'b00};
      total++;
      if ({pulso_a, ocupado_a, perdido_a} !== exp_v) begin
        bad++;
        $display("FAIL single k=%0d: got %b expected %b", k,
                 {pulso_a, ocupado_a, perdido_a}, exp_v);
      end
    end
  endtask

  // Default build: strobes in ATIVO and PAUSA are dropped.
  // Retrigger build: a strobe 2 cycles in extends the pulse to 6 cycles and a
  // later strobe in PAUSA is still dropped.
  task automatic test_drop();
    logic [5:0] exp_v;
    int p_end, o_end, d_from, s2, s3;
    if (RETRIG) begin
      s2 = 1; s3 = 6; p_end = 6; o_end = 8; d_from = 7;
    end else begin
      s2 = 1; s3 = 4; p_end = 4; o_end = 6; d_from = 2;
    end
    do_reset();
    dispara_a = 2'b01;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      dispara_a = (k == s2 || k == s3) ? 2'b01 : 2'b00;
      exp_v = {1'b0, 1'(k < p_end), 1'b0, 1'(k < o_end), 1'b0, 1'(k >= d_from)};
      total++;
      if ({pulso_a, ocupado_a, perdido_a} !== exp_v) begin
        bad++;
        $display("FAIL drop k=%0d: got %b expected %b", k,
                 {pulso_a, ocupado_a, perdido_a}, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_v;
    do_reset();
    dispara_a = 2'b01;
    @(negedge clk);
    dispara_a = 2'b00;
    for (int w = 0; w < 20 && ocupado_a[0]; w++) @(negedge clk);
    total++;
    if (ocupado_a[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_timeout: got ocupado=%b expected 0 within 20 cycles", ocupado_a[0]);
    end
    // First cycle after ocupado fell: accepted. Strobe at k==5 lands on the
    // last PAUSA cycle: dropped, no new pulse.
    dispara_a = 2'b01;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      dispara_a = (k == 5) ? 2'b01 : 2'b00;
      exp_v = {1'b0, 1'(k < 4), 1'b0, 1'(k < 6), 1'b0, 1'(k >= 6)};
      total++;
      if ({pulso_a, ocupado_a, perdido_a} !== exp_v) begin
        bad++;
        $display("FAIL b2b k=%0d: got %b expected %b", k,
                 {pulso_a, ocupado_a, perdido_a}, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp_v;
    do_reset();
    dispara_a = 2'b01;
    @(negedge clk);
    dispara_a = 2'b01;           // second strobe inside the pulse
    @(negedge clk);
    dispara_a = 2'b00;
    total++;
    if (pulso_a !== 2'b01) begin
      bad++;
      $display("FAIL mid_before: got pulso=%b expected 01", pulso_a);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({pulso_a, ocupado_a, perdido_a} !== 6'b0) begin
      bad++;
      $display("FAIL mid_async: got %b expected 000000", {pulso_a, ocupado_a, perdido_a});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dispara_a = 2'b01;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      dispara_a = 2'b00;
      exp_v = {1'b0, 1'(k < 4), 1'b0, 1'(k < 6), 2'b00};
      total++;
      if ({pulso_a, ocupado_a, perdido_a} !== exp_v) begin
        bad++;
        $display("FAIL mid_after k=%0d: got %b expected %b", k,
                 {pulso_a, ocupado_a, perdido_a}, exp_v);
      end
    end
  endtask

  // GAP_LEN = 0 with dispara held high: default build gives 3 high / 1 low
  // (the strobe on the last ATIVO cycle is dropped); retrigger stays high.
  task automatic test_gap0();
    logic [2:0] exp_v;
    do_reset();
    dispara_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (RETRIG) exp_v = 3'b110;
      else        exp_v = {1'((k % 4) < 3), 1'((k % 4) < 3), 1'(k >= 1)};
      total++;
      if ({pulso_b, ocupado_b, perdido_b} !== exp_v) begin
        bad++;
        $display("FAIL gap0 k=%0d: got %b expected %b", k,
                 {pulso_b, ocupado_b, perdido_b}, exp_v);
      end
    end
    dispara_b = 1'b0;
  endtask

  task automatic test_random();
    int         sa [2];
    bit         pa [2];
    int         sb;
    bit         pb;
    int         cyc;
    logic [1:0] da;
    logic       db;
    logic [5:0] exp_a;
    logic [2:0] exp_b;
    do_reset();
    sa  = '{-1000, -1000};
    pa  = '{1'b0, 1'b0};
    sb  = -1000;
    pb  = 1'b0;
    cyc = 0;
    for (int n = 0; n < 600; n++) begin
      da[0] = ($urandom_range(0, 3) == 0);
      da[1] = ($urandom_range(0, 2) == 0);
      db    = ($urandom_range(0, 2) == 0);
      dispara_a = da;
      dispara_b = db;
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_step(cyc, da[i], PA, GA, sa[i], pa[i]);
      model_step(cyc, db, PB, GB, sb, pb);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        exp_a[4 + i] = (cyc >= sa[i]) && (cyc <= sa[i] + PA - 1);
        exp_a[2 + i] = (cyc >= sa[i]) && (cyc <= sa[i] + PA + GA - 1);
        exp_a[i]     = pa[i];
      end
      exp_b = {1'((cyc >= sb) && (cyc <= sb + PB - 1)),
               1'((cyc >= sb) && (cyc <= sb + PB + GB - 1)), pb};
      total++;
      if ({pulso_a, ocupado_a, perdido_a} !== exp_a) begin
        bad++;
        $display("FAIL rand_a cyc=%0d: got %b expected %b", cyc,
                 {pulso_a, ocupado_a, perdido_a}, exp_a);
      end
      total++;
      if ({pulso_b, ocupado_b, perdido_b} !== exp_b) begin
        bad++;
        $display("FAIL rand_b cyc=%0d: got %b expected %b", cyc,
                 {pulso_b, ocupado_b, perdido_b}, exp_b);
      end
    end
    dispara_a = '0;
    dispara_b = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_gap0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
